ifu_fetch_ctrl: RTL and testbench

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

---
 rtl/ifu_fetch_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
// +--------------------------------------------------------------------------+
// | ifu_fetch_ctrl : credit-limited AXI instruction fetcher with jump flush  |
// | Optional IFU_FETCH_ERR_EN adds fetch_err_o from the response rresp.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ifu_fetch_ctrl #(
  parameter int                          OUTSTANDING_MAX = 2,
  parameter logic [`INST_ADDR_WIDTH-1:0] PC_RESET        = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        jump_flag_i,
  input  logic [`INST_ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                        stall_i,
  output logic [`INST_ADDR_WIDTH-1:0] axi_araddr_o,
  output logic                        axi_arvalid_o,
  input  logic                        axi_arready_i,
  input  logic [`INST_DATA_WIDTH-1:0] axi_rdata_i,
  input  logic [1:0]                  axi_rresp_i,
  input  logic                        axi_rvalid_i,
  output logic                        axi_rready_o,
  output logic [`INST_DATA_WIDTH-1:0] inst_o,
  output logic [`INST_ADDR_WIDTH-1:0] inst_addr_o,
  output logic                        inst_valid_o,
  output logic [`INST_ADDR_WIDTH-1:0] pc_o
`ifdef IFU_FETCH_ERR_EN
  ,
  output logic                        fetch_err_o
`endif
);

  localparam int c_AW = `INST_ADDR_WIDTH;
  localparam int c_DW = `INST_DATA_WIDTH;
  localparam int c_CW = $clog2(OUTSTANDING_MAX + 1);
  localparam int c_IW = (OUTSTANDING_MAX > 1) ? $clog2(OUTSTANDING_MAX) : 1;
  localparam int c_SW = c_CW + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_AW-1:0]   r_pc;
  logic              r_rready;
  logic              r_ar_pend, r_ar_stale;
  logic [c_AW-1:0]   r_ar_addr;
  logic [c_CW-1:0]   r_out, r_stale, r_fcnt;
  logic [c_IW-1:0]   r_qwr, r_qrd, r_fwr, r_frd;
  logic [c_AW-1:0]   r_q_addr [OUTSTANDING_MAX];
  logic [c_AW-1:0]   r_f_addr [OUTSTANDING_MAX];
  logic [c_DW-1:0]   r_f_data [OUTSTANDING_MAX];
`ifdef IFU_FETCH_ERR_EN
  logic [1:0]        r_f_resp [OUTSTANDING_MAX];
`else
  logic              w_unused_rresp;
  assign w_unused_rresp = ^axi_rresp_i;
`endif

  logic [c_SW-1:0]   w_used;
  logic              w_credit, w_arvalid, w_ar_hs, w_ar_stale;
  logic [c_AW-1:0]   w_araddr;
  logic              w_r_hs, w_r_stale, w_r_live, w_push, w_pop, w_valid, w_q_push;
  logic              w_pend_nxt, w_pend_stale_nxt;
  logic [c_CW-1:0]   w_out_nxt, w_stale_nxt;

  function automatic logic [c_IW-1:0] f_inc(input logic [c_IW-1:0] p);
    return (p == c_IW'(OUTSTANDING_MAX - 1)) ? '0 : p + c_IW'(1);
  endfunction

  // Stale requests count against credit too, so a response can never overrun the FIFO.
  assign w_used     = c_SW'(r_out) + c_SW'(r_stale) + c_SW'(r_fcnt);
  assign w_credit   = w_used < c_SW'(OUTSTANDING_MAX);
  assign w_arvalid  = r_ar_pend | ((r_state == S_FETCH) & w_credit);
  assign w_araddr   = r_ar_pend ? r_ar_addr : r_pc;
  assign w_ar_hs    = w_arvalid & axi_arready_i;
  assign w_ar_stale = r_ar_pend & r_ar_stale;
  assign w_q_push   = w_ar_hs & ~w_ar_stale & ~jump_flag_i;

  // Responses are in order and stale requests are always older than live ones.
  assign w_r_hs    = axi_rvalid_i & r_rready;
  assign w_r_stale = w_r_hs & (r_stale != '0);
  assign w_r_live  = w_r_hs & (r_stale == '0) & (r_out != '0);
  assign w_push    = w_r_live & ~jump_flag_i;
  assign w_valid   = (r_fcnt != '0);
  assign w_pop     = w_valid & ~stall_i & ~jump_flag_i;

  assign w_pend_nxt       = w_arvalid & ~axi_arready_i;
  assign w_pend_stale_nxt = w_pend_nxt & (w_ar_stale | jump_flag_i);

  always_comb begin
    w_out_nxt   = r_out;
    w_stale_nxt = r_stale;
    if (jump_flag_i) begin
      w_out_nxt   = '0;
      w_stale_nxt = r_stale + r_out + c_CW'(w_ar_hs) - c_CW'(w_r_stale | w_r_live);
    end else begin
      w_out_nxt   = r_out + c_CW'(w_q_push) - c_CW'(w_r_live);
      w_stale_nxt = r_stale + c_CW'(w_ar_hs & w_ar_stale) - c_CW'(w_r_stale);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: if (jump_flag_i && ((w_stale_nxt != '0) || w_pend_stale_nxt))
                 w_state_nxt = S_DRAIN;
      S_DRAIN: if (!jump_flag_i && (w_stale_nxt == '0) && !w_pend_stale_nxt)
                 w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= PC_RESET;
      r_rready   <= 1'b0;
      r_ar_pend  <= 1'b0;
      r_ar_stale <= 1'b0;
      r_ar_addr  <= '0;
      r_out      <= '0;
      r_stale    <= '0;
      r_fcnt     <= '0;
      r_qwr      <= '0;
      r_qrd      <= '0;
      r_fwr      <= '0;
      r_frd      <= '0;
      for (int i = 0; i < OUTSTANDING_MAX; i++) begin
        r_f_addr[i] <= '0;
        r_f_data[i] <= '0;
`ifdef IFU_FETCH_ERR_EN
        r_f_resp[i] <= '0;
`endif
      end
    end else begin
      r_rready   <= 1'b1;
      r_out      <= w_out_nxt;
      r_stale    <= w_stale_nxt;
      r_ar_pend  <= w_pend_nxt;
      r_ar_stale <= w_pend_stale_nxt;
      // Capture the address once so it stays stable across a redirect.
      if (w_pend_nxt && !r_ar_pend)
        r_ar_addr <= r_pc;

      if (jump_flag_i)
        r_pc <= jump_addr_i;
      else if (w_q_push)
        r_pc <= r_pc + c_AW'(4);

      if (jump_flag_i) begin
        r_qwr  <= '0;
        r_qrd  <= '0;
        r_fwr  <= '0;
        r_frd  <= '0;
        r_fcnt <= '0;
      end else begin
        if (w_q_push) begin
          r_q_addr[r_qwr] <= w_araddr;
          r_qwr           <= f_inc(r_qwr);
        end
        if (w_r_live)
          r_qrd <= f_inc(r_qrd);
        if (w_push) begin
          r_f_addr[r_fwr] <= r_q_addr[r_qrd];
          r_f_data[r_fwr] <= axi_rdata_i;
`ifdef IFU_FETCH_ERR_EN
          r_f_resp[r_fwr] <= axi_rresp_i;
`endif
          r_fwr <= f_inc(r_fwr);
        end
        if (w_pop)
          r_frd <= f_inc(r_frd);
        r_fcnt <= r_fcnt + c_CW'(w_push) - c_CW'(w_pop);
      end
    end
  end

  assign axi_arvalid_o = w_arvalid;
  assign axi_araddr_o  = w_araddr;
  assign axi_rready_o  = r_rready;
  assign inst_valid_o  = w_valid;
  assign inst_o        = r_f_data[r_frd];
  assign inst_addr_o   = r_f_addr[r_frd];
  assign pc_o          = r_pc;
`ifdef IFU_FETCH_ERR_EN
  assign fetch_err_o   = w_valid & (r_f_resp[r_frd] != 2'b00);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
// +--------------------------------------------------------------------------+
// | tb_ifu_fetch_ctrl : directed bench for ifu_fetch_ctrl with AXI slave     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] c_PC0 = 32'h8000_0000;

  logic        clk, rst, jump_flag, stall, arready, rvalid;
  logic [31:0] jump_addr, rdata, araddr, inst, inst_addr, pc;
  logic [1:0]  rresp;
  logic        arvalid, rready, inst_valid;
`ifdef IFU_FETCH_ERR_EN
  logic        fetch_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int lat      = 1;
  int err_beat = -1;
  int beat_idx;

  typedef struct { logic [31:0] addr; int due; } rd_t;
  rd_t         sq[$];
  logic [31:0] del_addr[$];
  logic [31:0] del_data[$];
  logic [31:0] ar_addr_log[$];
  int          ar_cyc_log[$];

  ifu_fetch_ctrl #(.OUTSTANDING_MAX(2), .PC_RESET(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .stall_i(stall), .axi_araddr_o(araddr), .axi_arvalid_o(arvalid),
    .axi_arready_i(arready), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready), .inst_o(inst),
    .inst_addr_o(inst_addr), .inst_valid_o(inst_valid), .pc_o(pc)
`ifdef IFU_FETCH_ERR_EN
    , .fetch_err_o(fetch_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // In-order AXI slave: a beat for an AR accepted in cycle k appears in cycle k+lat.
  always @(posedge clk) begin
    if (rst) begin
      sq.delete();
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= '0;
      beat_idx = 0;
    end else begin
      if (arvalid && arready) sq.push_back('{araddr, cyc + lat});
      if (!(rvalid && !rready)) begin
        if (sq.size() > 0 && sq[0].due <= cyc + 1) begin
          rvalid <= 1'b1;
          rdata  <= mem_word(sq[0].addr);
          rresp  <= (beat_idx == err_beat) ? 2'b10 : 2'b00;
          beat_idx = beat_idx + 1;
          void'(sq.pop_front());
        end else begin
          rvalid <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
    if (!rst && arvalid && arready) begin
      ar_addr_log.push_back(araddr);
      ar_cyc_log.push_back(cyc);
    end
    if (!rst && inst_valid && !stall && !jump_flag) begin
      del_addr.push_back(inst_addr);
      del_data.push_back(inst);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1; jump_flag = 1'b0; stall = 1'b0; arready = 1'b1;
    jump_addr = '0; lat = l; err_beat = -1;
    repeat (3) step();
    del_addr.delete(); del_data.delete(); ar_addr_log.delete(); ar_cyc_log.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    repeat (4) step();
    rst = 1'b1;
    step();
    n_checks++; if (pc !== c_PC0) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", pc, c_PC0); end
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b expected 0", arvalid); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b expected 0", rready); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h expected 0", inst); end
    n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL rst_inst_addr: got %h expected 0", inst_addr); end
  endtask

  task automatic test_first_fetch();
    int t;
    do_reset(1);
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL ff_c0_arvalid: got %b expected 0", arvalid); end
    step();
    n_checks++; if (arvalid !== 1'b1 || araddr !== c_PC0) begin n_fail++; $display("FAIL ff_c1_ar: got %b/%h expected 1/%h", arvalid, araddr, c_PC0); end
    step();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL ff_c2_valid: got %b expected 0", inst_valid); end
    step();
    n_checks++; if (inst_valid !== 1'b1 || inst_addr !== c_PC0 || inst !== mem_word(c_PC0)) begin
      n_fail++; $display("FAIL ff_c3_inst: got %b/%h/%h expected 1/%h/%h", inst_valid, inst_addr, inst, c_PC0, mem_word(c_PC0)); end
    n_checks++; if (pc !== c_PC0 + 32'd8 || arvalid !== 1'b0) begin
      n_fail++; $display("FAIL ff_c3_credit: got pc %h arvalid %b expected %h 0", pc, arvalid, c_PC0 + 32'd8); end
    t = 0;
    while (del_addr.size() < 6 && t < 60) begin step(); t++; end
    n_checks++;
    if (del_addr.size() < 6) begin n_fail++; $display("FAIL ff_timeout: got %0d expected 6", del_addr.size()); end
    else for (int i = 0; i < 6; i++) begin
      if (i > 0) n_checks++;
      if (del_addr[i] !== c_PC0 + 32'(4*i) || del_data[i] !== mem_word(c_PC0 + 32'(4*i))) begin
        n_fail++; $display("FAIL ff_seq%0d: got %h/%h expected %h", i, del_addr[i], del_data[i], c_PC0 + 32'(4*i)); end
    end
  endtask

  task automatic test_stall();
    int t;
    bit held;
    logic [31:0] h, maxa;
    do_reset(1);
    t = 0;
    while (inst_valid !== 1'b1 && t < 20) begin step(); t++; end
    stall = 1'b1;
    h = inst_addr;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inst_valid !== 1'b1 || inst_addr !== h) held = 1'b0;
    end
    n_checks++; if (held !== 1'b1 || h !== c_PC0) begin n_fail++; $display("FAIL st_hold: got held %b head %h expected 1 %h", held, h, c_PC0); end
    maxa = h;
    foreach (ar_addr_log[i]) if (ar_addr_log[i] > maxa) maxa = ar_addr_log[i];
    n_checks++; if (maxa - h > 32'd8) begin n_fail++; $display("FAIL st_credit: got %0d ARs beyond expected <=2", (maxa - h) / 4); end
    stall = 1'b0;
    t = 0;
    while (del_addr.size() < 8 && t < 80) begin step(); t++; end
    n_checks++;
    if (del_addr.size() < 8) begin n_fail++; $display("FAIL st_timeout: got %0d expected 8", del_addr.size()); end
    else for (int i = 0; i < 8; i++) begin
      if (i > 0) n_checks++;
      if (del_addr[i] !== c_PC0 + 32'(4*i) || del_data[i] !== mem_word(c_PC0 + 32'(4*i))) begin
        n_fail++; $display("FAIL st_seq%0d: got %h/%h expected %h", i, del_addr[i], del_data[i], c_PC0 + 32'(4*i)); end
    end
  endtask

  task automatic test_jump_drain();
    int t, k;
    bit quiet;
    do_reset(3);
    repeat (3) step();
    jump_flag = 1'b1; jump_addr = 32'h8000_0100;
    step();
    jump_flag = 1'b0;
    n_checks++; if (pc !== 32'h8000_0100) begin n_fail++; $display("FAIL jd_pc: got %h expected 80000100", pc); end
    quiet = 1'b1;
    for (int i = 0; i < 2; i++) begin if (arvalid !== 1'b0) quiet = 1'b0; step(); end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL jd_drain_quiet: got AR during drain expected none"); end
    t = 0;
    while (del_addr.size() < 3 && t < 60) begin step(); t++; end
    k = -1;
    foreach (ar_cyc_log[i]) if (k < 0 && ar_cyc_log[i] > 3) k = i;
    n_checks++;
    if (k < 0) begin n_fail++; $display("FAIL jd_next_ar: got none expected 80000100 @6"); end
    else if (ar_addr_log[k] !== 32'h8000_0100 || ar_cyc_log[k] != 6) begin
      n_fail++; $display("FAIL jd_next_ar: got %h @%0d expected 80000100 @6", ar_addr_log[k], ar_cyc_log[k]); end
    n_checks++;
    if (del_addr.size() < 3) begin n_fail++; $display("FAIL jd_timeout: got %0d expected 3", del_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      if (i > 0) n_checks++;
      if (del_addr[i] !== 32'h8000_0100 + 32'(4*i) || del_data[i] !== mem_word(32'h8000_0100 + 32'(4*i))) begin
        n_fail++; $display("FAIL jd_seq%0d: got %h expected %h", i, del_addr[i], 32'h8000_0100 + 32'(4*i)); end
    end
  endtask

  task automatic test_jump_pending();
    int t;
    bit stable;
    do_reset(1);
    arready = 1'b0;
    step();
    n_checks++; if (arvalid !== 1'b1 || araddr !== c_PC0) begin n_fail++; $display("FAIL jp_c1_ar: got %b/%h expected 1/%h", arvalid, araddr, c_PC0); end
    jump_flag = 1'b1; jump_addr = 32'h8000_0100;
    step();
    jump_flag = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (arvalid !== 1'b1 || araddr !== c_PC0 || pc !== 32'h8000_0100) stable = 1'b0;
      if (i == 2) arready = 1'b1;
      else step();
    end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL jp_hold: got unstable AR expected %h held", c_PC0); end
    t = 0;
    while (del_addr.size() < 2 && t < 60) begin step(); t++; end
    n_checks++;
    if (ar_addr_log.size() < 2) begin n_fail++; $display("FAIL jp_ar_log: got %0d ARs expected >=2", ar_addr_log.size()); end
    else if (ar_addr_log[0] !== c_PC0 || ar_cyc_log[0] != 4 || ar_addr_log[1] !== 32'h8000_0100 || ar_cyc_log[1] != 6) begin
      n_fail++; $display("FAIL jp_ar_log: got %h@%0d %h@%0d expected 80000000@4 80000100@6",
                         ar_addr_log[0], ar_cyc_log[0], ar_addr_log[1], ar_cyc_log[1]); end
    n_checks++;
    if (del_addr.size() < 2) begin n_fail++; $display("FAIL jp_timeout: got %0d expected 2", del_addr.size()); end
    else if (del_addr[0] !== 32'h8000_0100 || del_addr[1] !== 32'h8000_0104) begin
      n_fail++; $display("FAIL jp_seq: got %h %h expected 80000100 80000104", del_addr[0], del_addr[1]); end
  endtask

  task automatic test_double_jump();
    int t, k;
    bit saw100;
    do_reset(3);
    repeat (3) step();
    jump_flag = 1'b1; jump_addr = 32'h8000_0100;
    step();
    jump_addr = 32'h8000_0200;
    step();
    jump_flag = 1'b0;
    n_checks++; if (pc !== 32'h8000_0200) begin n_fail++; $display("FAIL dj_pc: got %h expected 80000200", pc); end
    t = 0;
    while (del_addr.size() < 3 && t < 60) begin step(); t++; end
    k = -1;
    saw100 = 1'b0;
    foreach (ar_cyc_log[i]) begin
      if (k < 0 && ar_cyc_log[i] > 4) k = i;
      if (ar_addr_log[i] == 32'h8000_0100) saw100 = 1'b1;
    end
    n_checks++;
    if (k < 0 || saw100) begin n_fail++; $display("FAIL dj_next_ar: got idx %0d saw100 %b expected 80000200 only", k, saw100); end
    else if (ar_addr_log[k] !== 32'h8000_0200 || ar_cyc_log[k] != 6) begin
      n_fail++; $display("FAIL dj_next_ar: got %h @%0d expected 80000200 @6", ar_addr_log[k], ar_cyc_log[k]); end
    n_checks++;
    if (del_addr.size() < 3) begin n_fail++; $display("FAIL dj_timeout: got %0d expected 3", del_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      if (i > 0) n_checks++;
      if (del_addr[i] !== 32'h8000_0200 + 32'(4*i) || del_data[i] !== mem_word(32'h8000_0200 + 32'(4*i))) begin
        n_fail++; $display("FAIL dj_seq%0d: got %h expected %h", i, del_addr[i], 32'h8000_0200 + 32'(4*i)); end
    end
  endtask

`ifdef IFU_FETCH_ERR_EN
  task automatic test_fetch_err();
    logic exp_err;
    do_reset(1);
    err_beat = 1;
    for (int c = 0; c < 10; c++) begin
      stall = (c == 4 || c == 5);
      exp_err = (c >= 4 && c <= 6);
      n_checks++;
      if (fetch_err !== exp_err) begin n_fail++; $display("FAIL err_c%0d: got %b expected %b", c, fetch_err, exp_err); end
      if (c == 4) begin
        n_checks++;
        if (inst_addr !== c_PC0 + 32'd4) begin n_fail++; $display("FAIL err_head: got %h expected %h", inst_addr, c_PC0 + 32'd4); end
      end
      step();
    end
    stall = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; jump_flag = 1'b0; stall = 1'b0; arready = 1'b1; jump_addr = '0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_jump_drain();
    test_jump_pending();
    test_double_jump();
`ifdef IFU_FETCH_ERR_EN
    test_fetch_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
